// File: rtl/dec_onehot_seq_pkg.sv
// Shared command encodings for the one-hot index sequencer.
// Imported by the top level and the testbench.
package dec_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  localparam int W_MIN = 1;
  localparam int W_MAX = 6;

endpackage

// File: rtl/dec_onehot_seq_if.sv
// Command/status bundle for dec_onehot_seq: the master issues commands,
// and the slave (the sequencer) returns the registered index, one-hot and limit.
interface dec_onehot_seq_if #(
  parameter int W = 2
) ();

  logic               en;
  logic [1:0]         mode;
  logic [W-1:0]       i;
  logic [(2**W)-1:0]  o;
  logic [W-1:0]       idx;
  logic               limit;

  modport master (
    output en, mode, i,
    input  o, idx, limit
  );

  modport slave (
    input  en, mode, i,
    output o, idx, limit
  );

endinterface

// File: rtl/dec_onehot_seq_core.sv
// Purely combinational W-to-2^W one-hot decoder.
module dec_core #(
  parameter int W = 2
) (
  input  logic [W-1:0]      idx,
  output logic [(2**W)-1:0] onehot
);

  localparam int N = 2**W;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_line
      assign onehot[gi] = (idx == W'(gi));
    end
  endgenerate

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with a load/hold/up/down index sequencer.
// IDX, O and LIMIT all come straight from one register stage.
module dec_onehot_seq
  import dec_pkg::*;
#(
  parameter int W    = 2,
  parameter bit WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  dec_onehot_seq_if.slave  bus
);

  localparam int N = 2**W;
  localparam logic [W-1:0] IDX_MAX = {W{1'b1}};
  localparam logic [W-1:0] IDX_MIN = '0;
  localparam logic [N-1:0] O_RST   = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0] idx_reg;
  logic [W-1:0] idx_next;
  logic [N-1:0] o_reg;
  logic [N-1:0] o_next;
  logic         limit_reg;
  logic         limit_next;

  // At a boundary the W-bit add/subtract overflows naturally, which is the wrap case.
  always_comb begin
    idx_next   = idx_reg;
    limit_next = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: idx_next = idx_reg;
        MODE_LOAD: idx_next = bus.i;
        MODE_UP: begin
          if (idx_reg == IDX_MAX) begin
            limit_next = 1'b1;
            idx_next   = WRAP ? (idx_reg + 1'b1) : idx_reg;
          end else begin
            idx_next   = idx_reg + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (idx_reg == IDX_MIN) begin
            limit_next = 1'b1;
            idx_next   = WRAP ? (idx_reg - 1'b1) : idx_reg;
          end else begin
            idx_next   = idx_reg - 1'b1;
          end
        end
        default: idx_next = idx_reg;
      endcase
    end
  end

  // Decoding the next index lets O be registered alongside IDX, keeping it glitch-free.
  dec_core #(.W(W)) u_core (
    .idx    (idx_next),
    .onehot (o_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= '0;
      o_reg     <= O_RST;
      limit_reg <= 1'b0;
    end else begin
      idx_reg   <= idx_next;
      o_reg     <= o_next;
      limit_reg <= limit_next;
    end
  end

  assign bus.idx   = idx_reg;
  assign bus.o     = o_reg;
  assign bus.limit = limit_reg;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Bench for dec_onehot_seq: directed vector table, multi-cycle corner sequences,
// and random commands on six parameter variants against a reference model.
module tb_dec_onehot_seq;
  import dec_pkg::*;

  localparam int NDUT = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en_r   [NDUT];
  logic [1:0]  mode_r [NDUT];
  logic [5:0]  i_r    [NDUT];
  logic [31:0] act_idx [NDUT];
  logic [31:0] act_o   [NDUT];
  logic [31:0] act_lim [NDUT];

  int n_t    [NDUT] = '{4, 4, 2, 2, 16, 16};
  bit wrap_t [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  int cmp_count  = 0;
  int fail_count = 0;
  bit onehot_on  = 1'b0;

  dec_onehot_seq_if #(.W(2)) bus_a ();
  dec_onehot_seq_if #(.W(2)) bus_b ();
  dec_onehot_seq_if #(.W(1)) bus_c ();
  dec_onehot_seq_if #(.W(1)) bus_d ();
  dec_onehot_seq_if #(.W(4)) bus_e ();
  dec_onehot_seq_if #(.W(4)) bus_f ();

  dec_onehot_seq #(.W(2), .WRAP(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  dec_onehot_seq #(.W(2), .WRAP(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  dec_onehot_seq #(.W(1), .WRAP(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));
  dec_onehot_seq #(.W(1), .WRAP(1'b0)) dut_d (.clk(clk), .rst(rst), .bus(bus_d.slave));
  dec_onehot_seq #(.W(4), .WRAP(1'b1)) dut_e (.clk(clk), .rst(rst), .bus(bus_e.slave));
  dec_onehot_seq #(.W(4), .WRAP(1'b0)) dut_f (.clk(clk), .rst(rst), .bus(bus_f.slave));

  assign bus_a.en = en_r[0]; assign bus_a.mode = mode_r[0]; assign bus_a.i = i_r[0][1:0];
  assign bus_b.en = en_r[1]; assign bus_b.mode = mode_r[1]; assign bus_b.i = i_r[1][1:0];
  assign bus_c.en = en_r[2]; assign bus_c.mode = mode_r[2]; assign bus_c.i = i_r[2][0:0];
  assign bus_d.en = en_r[3]; assign bus_d.mode = mode_r[3]; assign bus_d.i = i_r[3][0:0];
  assign bus_e.en = en_r[4]; assign bus_e.mode = mode_r[4]; assign bus_e.i = i_r[4][3:0];
  assign bus_f.en = en_r[5]; assign bus_f.mode = mode_r[5]; assign bus_f.i = i_r[5][3:0];

  assign act_idx[0] = 32'(bus_a.idx); assign act_o[0] = 32'(bus_a.o); assign act_lim[0] = 32'(bus_a.limit);
  assign act_idx[1] = 32'(bus_b.idx); assign act_o[1] = 32'(bus_b.o); assign act_lim[1] = 32'(bus_b.limit);
  assign act_idx[2] = 32'(bus_c.idx); assign act_o[2] = 32'(bus_c.o); assign act_lim[2] = 32'(bus_c.limit);
  assign act_idx[3] = 32'(bus_d.idx); assign act_o[3] = 32'(bus_d.o); assign act_lim[3] = 32'(bus_d.limit);
  assign act_idx[4] = 32'(bus_e.idx); assign act_o[4] = 32'(bus_e.o); assign act_lim[4] = 32'(bus_e.limit);
  assign act_idx[5] = 32'(bus_f.idx); assign act_o[5] = 32'(bus_f.o); assign act_lim[5] = 32'(bus_f.limit);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: index as a plain integer in 0..n-1.
  function automatic int ref_next(input int cur, input bit en, input logic [1:0] mode,
                                  input int iv, input int n, input bit wrap, output bit lim);
    lim = 1'b0;
    if (!en) return cur;
    if (mode == MODE_LOAD) return iv;
    if (mode == MODE_UP) begin
      if (cur == n - 1) begin
        lim = 1'b1;
        return wrap ? 0 : cur;
      end
      return cur + 1;
    end
    if (mode == MODE_DOWN) begin
      if (cur == 0) begin
        lim = 1'b1;
        return wrap ? n - 1 : cur;
      end
      return cur - 1;
    end
    return cur;
  endfunction

  // One-hot invariant on every DUT, every cycle outside reset.
  always @(negedge clk) begin
    if (onehot_on && !rst) begin
      for (int k = 0; k < NDUT; k++)
        check("onehot", act_o[k], 32'(1) << act_idx[k]);
    end
  end

  typedef struct {
    bit         en;
    logic [1:0] mode;
    int         iv;
    int         exp_idx;
    bit         exp_lim;
  } vec_t;

  vec_t tbl [18];

  int  model_idx [NDUT];
  bit  model_lim [NDUT];

  initial begin
    tbl[0]  = '{1'b1, MODE_LOAD, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, MODE_LOAD, 1, 1, 1'b0};
    tbl[2]  = '{1'b1, MODE_LOAD, 2, 2, 1'b0};
    tbl[3]  = '{1'b1, MODE_LOAD, 3, 3, 1'b0};
    tbl[4]  = '{1'b1, MODE_LOAD, 2, 2, 1'b0};
    tbl[5]  = '{1'b1, MODE_UP,   0, 3, 1'b0};
    tbl[6]  = '{1'b1, MODE_UP,   0, 0, 1'b1};
    tbl[7]  = '{1'b1, MODE_UP,   0, 1, 1'b0};
    tbl[8]  = '{1'b1, MODE_LOAD, 0, 0, 1'b0};
    tbl[9]  = '{1'b1, MODE_DOWN, 0, 3, 1'b1};
    tbl[10] = '{1'b1, MODE_DOWN, 0, 2, 1'b0};
    tbl[11] = '{1'b0, MODE_LOAD, 3, 2, 1'b0};
    tbl[12] = '{1'b1, MODE_UP,   0, 3, 1'b0};
    tbl[13] = '{1'b0, MODE_UP,   0, 3, 1'b0};
    tbl[14] = '{1'b1, MODE_UP,   0, 0, 1'b1};
    tbl[15] = '{1'b0, MODE_UP,   0, 0, 1'b0};
    tbl[16] = '{1'b1, MODE_UP,   0, 1, 1'b0};
    tbl[17] = '{1'b1, MODE_HOLD, 0, 1, 1'b0};

    for (int k = 0; k < NDUT; k++) begin
      en_r[k] = 1'b0; mode_r[k] = MODE_HOLD; i_r[k] = '0;
    end

    // Power-on reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_idx", act_idx[0], 0);
    check("rst_o",   act_o[0],   1);
    check("rst_lim", act_lim[0], 0);
    @(negedge clk);
    rst = 1'b0;
    onehot_on = 1'b1;

    // Directed table on W=2, WRAP=1.
    for (int r = 0; r < 18; r++) begin
      en_r[0] = tbl[r].en; mode_r[0] = tbl[r].mode; i_r[0] = 6'(tbl[r].iv);
      step();
      $display("vec %0d: en=%0d mode=%0d i=%0d -> idx=%0d o=%0h limit=%0d",
               r, tbl[r].en, tbl[r].mode, tbl[r].iv, act_idx[0], act_o[0], act_lim[0]);
      check("vec_idx", act_idx[0], 32'(tbl[r].exp_idx));
      check("vec_o",   act_o[0],   32'(1) << tbl[r].exp_idx);
      check("vec_lim", act_lim[0], 32'(tbl[r].exp_lim));
    end
    en_r[0] = 1'b0;

    // Saturation on W=2, WRAP=0.
    en_r[1] = 1'b1; mode_r[1] = MODE_LOAD; i_r[1] = 6'd3;
    step(); $display("sat load3 -> idx=%0d", act_idx[1]);
    check("sat_load", act_idx[1], 3);
    mode_r[1] = MODE_UP;
    for (int k = 0; k < 2; k++) begin
      step(); $display("sat up -> idx=%0d o=%0h limit=%0d", act_idx[1], act_o[1], act_lim[1]);
      check("sat_up_idx", act_idx[1], 3);
      check("sat_up_o",   act_o[1],   8);
      check("sat_up_lim", act_lim[1], 1);
    end
    mode_r[1] = MODE_DOWN;
    step(); $display("sat down -> idx=%0d limit=%0d", act_idx[1], act_lim[1]);
    check("sat_dn_idx", act_idx[1], 2);
    check("sat_dn_lim", act_lim[1], 0);
    mode_r[1] = MODE_LOAD; i_r[1] = 6'd0;
    step();
    mode_r[1] = MODE_DOWN;
    step(); $display("sat down at 0 -> idx=%0d limit=%0d", act_idx[1], act_lim[1]);
    check("sat_lo_idx", act_idx[1], 0);
    check("sat_lo_lim", act_lim[1], 1);

    // Asynchronous reset mid-cycle with non-reset state and LIMIT high.
    en_r[0] = 1'b1; mode_r[0] = MODE_LOAD; i_r[0] = 6'd3;
    mode_r[1] = MODE_LOAD; i_r[1] = 6'd3;
    step();
    en_r[0] = 1'b0; mode_r[1] = MODE_UP;
    step();
    en_r[1] = 1'b0;
    check("pre_rst_lim", act_lim[1], 1);
    #3 rst = 1'b1;
    #1;
    $display("async rst -> a idx=%0d o=%0h, b idx=%0d limit=%0d", act_idx[0], act_o[0], act_idx[1], act_lim[1]);
    check("arst_a_idx", act_idx[0], 0);
    check("arst_a_o",   act_o[0],   1);
    check("arst_b_idx", act_idx[1], 0);
    check("arst_b_lim", act_lim[1], 0);
    @(negedge clk);
    rst = 1'b0;
    en_r[0] = 1'b1; mode_r[0] = MODE_LOAD; i_r[0] = 6'd2;
    step(); $display("first cmd after rst -> idx=%0d", act_idx[0]);
    check("post_rst_load", act_idx[0], 2);
    en_r[0] = 1'b0;

    // Re-synchronise every DUT with the model, then random commands.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < NDUT; k++) model_idx[k] = 0;

    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        en_r[k]   = ($urandom_range(0, 7) != 0);
        mode_r[k] = 2'($urandom_range(0, 3));
        i_r[k]    = 6'($urandom_range(0, n_t[k] - 1));
        model_idx[k] = ref_next(model_idx[k], en_r[k], mode_r[k], int'(i_r[k]),
                                n_t[k], wrap_t[k], model_lim[k]);
      end
      step();
      $display("rnd %0d: idx=%0d,%0d,%0d,%0d,%0d,%0d lim=%0d%0d%0d%0d%0d%0d", c,
               act_idx[0], act_idx[1], act_idx[2], act_idx[3], act_idx[4], act_idx[5],
               act_lim[0], act_lim[1], act_lim[2], act_lim[3], act_lim[4], act_lim[5]);
      for (int k = 0; k < NDUT; k++) begin
        check("rnd_idx", act_idx[k], 32'(model_idx[k]));
        check("rnd_lim", act_lim[k], 32'(model_lim[k]));
      end
    end

    onehot_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dec_onehot_seq.md
# dec_onehot_seq

Registered, parametrised W-to-2^W one-hot decoder with a built-in index sequencer. It generalises the team's combinational 2-to-4 decoder in two ways: the index is held in a register, and that index can be loaded, held, or stepped up or down with wrap-around or saturation. It drives one-hot select lines, such as bank, channel or phase enables, that must stay glitch-free and change only on a clock edge.

## Interface
Parameters:
- W, default 2: index width; output width N = 2**W (localparam), W in 1..6
- WRAP, default 1: 1 = stepping wraps modulo N; 0 = stepping saturates at 0 / N-1

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  command qualifier; when 0, state holds regardless of MODE
- MODE  in  2  command: 00 HOLD, 01 LOAD, 10 UP, 11 DOWN
- I  in  W  index to load (LOAD only)
- O  out  N  registered one-hot output, O == 1 << IDX at all times
- IDX  out  W  registered current index
- LIMIT  out  1  registered one-cycle pulse: a step crossed (WRAP=1) or hit (WRAP=0) the boundary

## Operation
- One clock, CLK; reset is asynchronous and active-high on RST.
- Reset values: IDX = 0, O = {N-1 zeros, 1} (bit 0 set), LIMIT = 0.
- Commands are sampled on a rising CLK edge when EN=1:
  - HOLD: IDX unchanged, LIMIT=0.
  - LOAD: IDX <= I, LIMIT=0. Every I value in 0..N-1 is legal; there are no illegal inputs.
  - UP: if IDX < N-1, then IDX <= IDX+1 and LIMIT=0.
    - At IDX = N-1 with WRAP=1: IDX <= 0, LIMIT=1.
    - At IDX = N-1 with WRAP=0: IDX holds, LIMIT=1.
  - DOWN: mirror of UP. At IDX = 0, WRAP=1 gives IDX <= N-1 and WRAP=0 holds; LIMIT=1 in both cases.
- EN=0: IDX and O hold, LIMIT=0 on that edge.
- O is computed from the next-state index and registered alongside IDX. O is never all-zero and never multi-hot, including directly after reset.
- Index arithmetic is W-bit unsigned. Wrap is the natural modulo-2^W overflow. The saturation compare is against the constant N-1 or 0.
- LIMIT is not sticky. Back-to-back UP commands at saturation with WRAP=0 pulse LIMIT every cycle.
- W=1 degenerate case: N=2, and UP/DOWN toggle between the two states.

## Timing
- Latency: one cycle. A command sampled at edge k is visible on O, IDX and LIMIT after edge k.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.
- RST asserted mid-sequence: outputs go to reset values immediately, without waiting for CLK. The first command is accepted on the first rising edge after RST deasserts.
- Commands use no handshake. Every EN=1 edge is executed, and there is no back-pressure.

## Structure
- Package dec_pkg holds the MODE encodings as named constants: MODE_HOLD, MODE_LOAD, MODE_UP, MODE_DOWN.
- Sub-module dec_core: a purely combinational parametrised W-to-2^W decoder (index in, one-hot out). It is instantiated once, on the next-state index.
- Top level: the next-index logic (a case on MODE), the boundary detect, and one register stage holding IDX, O and LIMIT.

## Test plan
- Reset: assert RST asynchronously mid-cycle -> O=0001, IDX=0, LIMIT=0 immediately, checked before the next CLK edge.
- LOAD sweep (W=2): load I = 0, 1, 2, 3 on consecutive edges -> O = 0001, 0010, 0100, 1000, each one cycle after its command. Assert O == 1<<IDX every cycle.
- Wrap up/down (WRAP=1, W=2):
  - From IDX=2, UP x3 -> IDX 3, 0, 1. LIMIT pulses only on the 3->0 step.
  - From IDX=0, DOWN -> IDX=3, LIMIT=1.
- Saturation (WRAP=0, W=2): from IDX=3, UP x2 -> IDX stays 3, O=1000, LIMIT=1 on both cycles. Then DOWN -> IDX=2, LIMIT=0.
- Enable gating: EN=0 with MODE=LOAD, I=3 -> O unchanged, LIMIT=0. Toggle EN every cycle with MODE=UP -> IDX advances only on EN=1 edges.
- Parameter sweep: W=1 and W=4 with random commands against a reference model. Check the one-hot invariant and that LIMIT matches the model on every cycle.
